// File: rtl/traffic_display.sv
// -----------------------------------------------------------------------------
// traffic_display
//
// Output stage of the traffic-light counter. Drives a 2-digit multiplexed,
// common-anode 7-segment display that shows the countdown value, plus three
// phase lamps. All outputs are registered.
//
// Optional feature macro: TRAFFIC_YELLOW_BLINK_EN
//   When defined, the yellow lamp blinks with a half-period of BLINK_DIV
//   clocks and starts lit on entry to the yellow phase. When undefined, the
//   yellow lamp is steady and BLINK_DIV is ignored.
//
// Parameters:
//   SCAN_DIV  - clocks per digit slot (>= 1)
//   BLINK_DIV - clocks per yellow blink half-period (>= 1)
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   count  - countdown value 0..15
//   gyr    - phase code: 0 green, 1 yellow, 2..7 red
//   seg    - segment drive, active-low, {g,f,e,d,c,b,a}
//   an     - digit enables, active-low; an[0] ones, an[1] tens
//   lamp_g - green lamp, active-high
//   lamp_y - yellow lamp, active-high
//   lamp_r - red lamp, active-high
// -----------------------------------------------------------------------------
module traffic_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count,
    input  logic [2:0] gyr,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       lamp_g,
    output logic       lamp_y,
    output logic       lamp_r
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

    // Active-low segment pattern for one decimal digit; out-of-range blanks.
    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] f;
        case (d)
            4'd0:    f = 7'h40;
            4'd1:    f = 7'h79;
            4'd2:    f = 7'h24;
            4'd3:    f = 7'h30;
            4'd4:    f = 7'h19;
            4'd5:    f = 7'h12;
            4'd6:    f = 7'h02;
            4'd7:    f = 7'h78;
            4'd8:    f = 7'h00;
            4'd9:    f = 7'h10;
            default: f = 7'h7F;
        endcase
        return f;
    endfunction

    logic [3:0]    cnt_r;
    logic [2:0]    gyr_r;
    logic [PW-1:0] prescale_r;
    logic          digit_sel_r;

    logic          tens_s;
    logic [3:0]    ones_s;
    logic          wrap_s;
    logic [6:0]    seg_nxt_s;
    logic [1:0]    an_nxt_s;
    logic          lamp_g_nxt_s;
    logic          lamp_y_sel_s;
    logic          lamp_y_nxt_s;
    logic          lamp_r_nxt_s;

    // Unconditional input capture; decouples the display from the counter stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 4'd0;
            gyr_r <= 3'd0;
        end else begin
            cnt_r <= count;
            gyr_r <= gyr;
        end
    end

    // BCD split: cnt_r never exceeds 15, so the tens digit is a single bit.
    always_comb begin
        tens_s = (cnt_r >= 4'd10);
        if (tens_s) begin
            ones_s = cnt_r - 4'd10;
        end else begin
            ones_s = cnt_r;
        end
    end

    assign wrap_s = (prescale_r == SCAN_LAST);

    // Scan prescaler; slot timing runs freely and is unaffected by data changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_r  <= '0;
            digit_sel_r <= 1'b0;
        end else if (wrap_s) begin
            prescale_r  <= '0;
            digit_sel_r <= ~digit_sel_r;
        end else begin
            prescale_r  <= prescale_r + {{(PW-1){1'b0}}, 1'b1};
            digit_sel_r <= digit_sel_r;
        end
    end

    // Digit multiplex; a zero tens digit is blanked rather than shown as '0'.
    always_comb begin
        seg_nxt_s = 7'h7F;
        an_nxt_s  = 2'b11;
        if (!digit_sel_r) begin
            an_nxt_s  = 2'b10;
            seg_nxt_s = font(ones_s);
        end else if (tens_s) begin
            an_nxt_s  = 2'b01;
            seg_nxt_s = font(4'd1);
        end else begin
            an_nxt_s  = 2'b11;
            seg_nxt_s = 7'h7F;
        end
    end

    // Lamp decode; every code above yellow is red, so exactly one lamp is lit.
    always_comb begin
        lamp_g_nxt_s = 1'b0;
        lamp_y_sel_s = 1'b0;
        lamp_r_nxt_s = 1'b0;
        case (gyr_r)
            3'd0:    lamp_g_nxt_s = 1'b1;
            3'd1:    lamp_y_sel_s = 1'b1;
            default: lamp_r_nxt_s = 1'b1;
        endcase
    end

`ifdef TRAFFIC_YELLOW_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_r;
    logic          blink_phase_r;

    // Blink timer; parked lit outside yellow so the lamp lights on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (gyr_r != 3'd1) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            blink_phase_r <= blink_phase_r;
        end
    end

    assign lamp_y_nxt_s = lamp_y_sel_s & blink_phase_r;
`else
    assign lamp_y_nxt_s = lamp_y_sel_s;
`endif

    // Output registers; reset blanks the display and darkens all lamps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg    <= 7'h7F;
            an     <= 2'b11;
            lamp_g <= 1'b0;
            lamp_y <= 1'b0;
            lamp_r <= 1'b0;
        end else begin
            seg    <= seg_nxt_s;
            an     <= an_nxt_s;
            lamp_g <= lamp_g_nxt_s;
            lamp_y <= lamp_y_nxt_s;
            lamp_r <= lamp_r_nxt_s;
        end
    end

endmodule

// File: tb/tb_traffic_display.sv
// -----------------------------------------------------------------------------
// tb_traffic_display
//
// Self-checking bench for traffic_display (SCAN_DIV=4, BLINK_DIV=3).
// A cycle-indexed model derives every output from the input history and the
// number of clock edges since reset release; directed steps add literal pins.
// Honours TRAFFIC_YELLOW_BLINK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_traffic_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 3;
    localparam int HMAX      = 1024;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic [2:0] gyr;
    logic [6:0] seg;
    logic [1:0] an;
    logic       lamp_g;
    logic       lamp_y;
    logic       lamp_r;

    int checks = 0;
    int errors = 0;

    int n_edges;
    int hist_count [HMAX];
    int hist_gyr   [HMAX];
    logic [6:0] font_t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    traffic_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .count  (count),
        .gyr    (gyr),
        .seg    (seg),
        .an     (an),
        .lamp_g (lamp_g),
        .lamp_y (lamp_y),
        .lamp_r (lamp_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release: the model's notion of time.
    always @(posedge clk or negedge reset) begin
        if (!reset) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    // Model + compare, once per cycle on the inactive edge.
    always @(negedge clk) begin : model_cmp
        int n, c, g, sel, run;
        logic [6:0] e_seg;
        logic [1:0] e_an;
        logic [2:0] e_lamp;
        n = n_edges;
        if (!reset || n == 0) begin
            e_seg = 7'h7F; e_an = 2'b11; e_lamp = 3'b000;
        end else begin
            // Output after edge n reflects inputs captured at edge n-1 and the
            // slot that was active during the cycle before edge n.
            c   = (n >= 2) ? hist_count[n-1] : 0;
            g   = (n >= 2) ? hist_gyr[n-1]   : 0;
            sel = ((n - 1) / SCAN_DIV) % 2;
            if (sel == 0) begin
                e_an = 2'b10; e_seg = font_t[c % 10];
            end else if (c >= 10) begin
                e_an = 2'b01; e_seg = 7'h79;
            end else begin
                e_an = 2'b11; e_seg = 7'h7F;
            end
            if (g == 0)      e_lamp = 3'b100;
            else if (g == 1) begin
                e_lamp = 3'b010;
`ifdef TRAFFIC_YELLOW_BLINK_EN
                run = 0;
                for (int j = n - 1; j >= 2 && hist_gyr[j] == 1; j--) run++;
                if (((run - 1) / BLINK_DIV) % 2 != 0) e_lamp = 3'b000;
`endif
            end
            else             e_lamp = 3'b001;
        end
        checks++;
        if (seg !== e_seg) begin
            errors++;
            $display("FAIL model_seg t=%0t n=%0d got=%h exp=%h", $time, n, seg, e_seg);
        end
        checks++;
        if (an !== e_an) begin
            errors++;
            $display("FAIL model_an t=%0t n=%0d got=%b exp=%b", $time, n, an, e_an);
        end
        checks++;
        if ({lamp_g, lamp_y, lamp_r} !== e_lamp) begin
            errors++;
            $display("FAIL model_lamps t=%0t n=%0d got=%b exp=%b", $time, n,
                     {lamp_g, lamp_y, lamp_r}, e_lamp);
        end
        checks++;
        if ($countones({lamp_g, lamp_y, lamp_r}) > 1) begin
            errors++;
            $display("FAIL lamp_onehot t=%0t got=%b exp=at most one", $time,
                     {lamp_g, lamp_y, lamp_r});
        end
        // Inputs now stable are what edge n+1 will capture.
        if (n + 1 < HMAX) begin
            hist_count[n+1] = count;
            hist_gyr[n+1]   = gyr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_lit(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Bounded wait for a digit slot, then pin the segment pattern shown in it.
    task automatic wait_slot(input logic [1:0] tgt, input logic [6:0] exp_seg, input string nm);
        int k;
        k = 0;
        while (an !== tgt && k < 20) begin
            tick();
            k++;
        end
        check_lit({nm, "_an"},  {10'd0, an},  {10'd0, tgt});
        check_lit({nm, "_seg"}, {5'd0, seg},  {5'd0, exp_seg});
    endtask

    initial begin : stim
        logic [11:0] pat;
        logic [11:0] exp_pat;
        reset = 1'b0;
        count = 4'd0;
        gyr   = 3'd0;
        repeat (3) tick();
        check_lit("rst_seg",   {5'd0, seg}, 12'h07F);
        check_lit("rst_an",    {10'd0, an}, 12'h003);
        check_lit("rst_lamps", {9'd0, lamp_g, lamp_y, lamp_r}, 12'h000);

        reset = 1'b1;
        tick(); tick();
        check_lit("rel_an",  {10'd0, an}, 12'h002);
        check_lit("rel_seg", {5'd0, seg}, 12'h040);
        check_lit("rel_g",   {11'd0, lamp_g}, 12'h001);

        count = 4'd7;
        tick(); tick(); tick();
        wait_slot(2'b10, 7'h78, "c7_ones");
        wait_slot(2'b11, 7'h7F, "c7_tens");

        count = 4'd15;
        tick(); tick(); tick();
        wait_slot(2'b10, 7'h12, "c15_ones");
        wait_slot(2'b01, 7'h79, "c15_tens");

        count = 4'd10;
        tick(); tick(); tick();
        wait_slot(2'b10, 7'h40, "c10_ones");
        wait_slot(2'b01, 7'h79, "c10_tens");

        gyr = 3'd0; tick();
        gyr = 3'd1; tick();
        gyr = 3'd2; tick();
        check_lit("step_y", {11'd0, lamp_y}, 12'h001);
        gyr = 3'd3; tick();
        check_lit("step_r2", {11'd0, lamp_r}, 12'h001);
        tick();
        check_lit("step_r3", {11'd0, lamp_r}, 12'h001);

        count = 4'd12;
        gyr   = 3'd2;
        repeat (5) tick();
        #1 reset = 1'b0;
        #1;
        check_lit("mid_rst_seg",   {5'd0, seg}, 12'h07F);
        check_lit("mid_rst_an",    {10'd0, an}, 12'h003);
        check_lit("mid_rst_lamps", {9'd0, lamp_g, lamp_y, lamp_r}, 12'h000);
        tick();
        reset = 1'b1;
        tick();
        check_lit("post_rst_an", {10'd0, an}, 12'h002);
        repeat (4) tick();

        gyr   = 3'd1;
        count = 4'd3;
        tick(); tick();
        for (int i = 0; i < 12; i++) begin
            pat[11-i] = lamp_y;
            tick();
        end
`ifdef TRAFFIC_YELLOW_BLINK_EN
        exp_pat = 12'b111000111000;
`else
        exp_pat = 12'b111111111111;
`endif
        check_lit("blink_pat", pat, exp_pat);

        gyr = 3'd0;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_display.md
Name: traffic_display

Overview:
- Downstream output stage of the traffic-light counter.
- Consumes the 4-bit countdown value `count` (0..15) and the phase code `gyr` (0 green, 1 yellow, other red).
- Drives a 2-digit multiplexed common-anode 7-segment display and three lamp outputs.
- All outputs are registered. Digit scanning is timed by an internal prescaler.

Parameters:
- SCAN_DIV, 50000, clocks per digit slot; legal range >= 1.
- BLINK_DIV, 25000000, clocks per yellow blink half-period; used only with the optional feature; legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- count  input  4  countdown value from the counter stage, 0..15.
- gyr  input  3  phase code: 0 green, 1 yellow, 2..7 red.
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- an  output  2  digit enables, active-low; an[0] is the ones digit, an[1] is the tens digit.
- lamp_g  output  1  green lamp, active-high.
- lamp_y  output  1  yellow lamp, active-high.
- lamp_r  output  1  red lamp, active-high.

Behaviour:
- Reset (asynchronous, active-low, takes effect immediately, also mid-operation):
  - cnt_q=0, gyr_q=0, prescaler=0, digit_sel=0.
  - seg=7'h7F, an=2'b11, lamp_g=0, lamp_y=0, lamp_r=0.
- Input capture: every clock, count -> cnt_q and gyr -> gyr_q. No handshake; inputs are sampled unconditionally.
- BCD split, combinational from cnt_q:
  - tens = (cnt_q >= 10).
  - ones = cnt_q - 10*tens, giving a value 0..9.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and then wraps to 0.
  - On the wrap cycle, digit_sel toggles.
  - SCAN_DIV=1 toggles digit_sel every clock.
- Output register, updated every clock from the current digit_sel and cnt_q:
  - digit_sel=0: an=2'b10, seg=font(ones).
  - digit_sel=1 with tens=1: an=2'b01, seg=font(1)=7'h79.
  - digit_sel=1 with tens=0: leading-zero blank, an=2'b11, seg=7'h7F.
- Font (hex, active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19
  - 5:12, 6:02, 7:78, 8:00, 9:10
- Lamp register, updated every clock from gyr_q; exactly one lamp is high out of reset:
  - gyr_q=0: lamp_g=1.
  - gyr_q=1: lamp_y=1.
  - gyr_q=2..7: lamp_r=1 (codes 3..7 are treated as red, matching the counter's default branch).
- Latency:
  - count/gyr input to seg/an/lamp output: 2 clocks.
  - A digit slot change is visible 1 clock after the prescaler wrap.
- Simultaneous events: a value change during a slot is shown in that same slot after the 2-clock latency; slot timing is not reset by data changes.
- Width rules:
  - Prescaler width is $clog2(SCAN_DIV), minimum 1 bit.
  - All arithmetic is unsigned.
  - ones is never out of range because cnt_q <= 15.

Optional Feature:
- Macro: TRAFFIC_YELLOW_BLINK_EN.
- Defined:
  - A blink counter runs 0..BLINK_DIV-1; a blink_phase flag toggles on each wrap.
  - lamp_y = (gyr_q==1) & blink_phase.
  - When gyr_q is not 1, the blink counter is held at 0 and blink_phase at 1, so yellow lights immediately on entry.
  - Reset: blink counter=0, blink_phase=1.
- Undefined: lamp_y is steady while gyr_q==1; no blink logic is present and BLINK_DIV is ignored.

Test Plan (SCAN_DIV=4, BLINK_DIV=3):
- Hold reset low for 3 clocks -> seg=7F, an=11, lamps all 0. Release with count=0, gyr=0 -> within 2 clocks an=10, seg=40, lamp_g=1.
- count=7 held -> ones slot: an=10, seg=78. Tens slot: an=11, seg=7F. Slots alternate every 4 clocks.
- count=15 held -> ones slot seg=12. Tens slot an=01, seg=79. Then count=10 -> ones slot seg=40, tens slot seg=79.
- gyr stepped 0,1,2,3, one value per clock -> lamps g, y, r, r, each 2 clocks after the input; never more than one lamp high.
- count=12, gyr=2, reset pulsed low mid-slot -> seg=7F, an=11, lamps 0 before the next clock edge. After release, the ones slot is shown first.
- Blink: gyr=1 held 12 clocks.
  - With TRAFFIC_YELLOW_BLINK_EN: lamp_y high 3, low 3, high 3, low 3.
  - Without the macro: lamp_y steady 1.
